// File: rtl/ar_arbiter_if.sv
// ar_arbiter_if: bundles the read-address (AR) signals around ar_arbiter.
//
// Signal names keep the _i/_o suffix as seen from the arbiter.
//   Master side (M0, M1): arid/araddr/arlen/arvalid in, arready out.
//   Slave side (S0, S1, SD): shared arids/araddr/arlen, one-hot arvalid out,
//   per-slave arready in, per-slave rdone pulse in (R handshake with rlast done).
//
// Modports:
//   master - used by the arbiter, which issues requests towards the slaves.
//   slave  - used by the environment: drives the master requests and the slave
//            responses, and observes the arbiter outputs.
interface ar_arbiter_if #(
    parameter int unsigned ID_BITS   = 4,
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned LEN_BITS  = 4
);
    logic [ID_BITS-1:0]   arid_m0_i;
    logic [ADDR_BITS-1:0] araddr_m0_i;
    logic [LEN_BITS-1:0]  arlen_m0_i;
    logic                 arvalid_m0_i;
    logic                 arready_m0_o;

    logic [ID_BITS-1:0]   arid_m1_i;
    logic [ADDR_BITS-1:0] araddr_m1_i;
    logic [LEN_BITS-1:0]  arlen_m1_i;
    logic                 arvalid_m1_i;
    logic                 arready_m1_o;

    logic [ID_BITS:0]     arids_s_o;
    logic [ADDR_BITS-1:0] araddr_s_o;
    logic [LEN_BITS-1:0]  arlen_s_o;
    logic [2:0]           arvalid_s_o;
    logic [2:0]           arready_s_i;
    logic [2:0]           rdone_i;

    modport master (
        input  arid_m0_i, araddr_m0_i, arlen_m0_i, arvalid_m0_i,
        output arready_m0_o,
        input  arid_m1_i, araddr_m1_i, arlen_m1_i, arvalid_m1_i,
        output arready_m1_o,
        output arids_s_o, araddr_s_o, arlen_s_o, arvalid_s_o,
        input  arready_s_i, rdone_i
    );

    modport slave (
        output arid_m0_i, araddr_m0_i, arlen_m0_i, arvalid_m0_i,
        input  arready_m0_o,
        output arid_m1_i, araddr_m1_i, arlen_m1_i, arvalid_m1_i,
        input  arready_m1_o,
        input  arids_s_o, araddr_s_o, arlen_s_o, arvalid_s_o,
        output arready_s_i, rdone_i
    );
endinterface

// File: rtl/ar_arbiter.sv
// ar_arbiter: AR channel arbiter sharing the read-address path between masters
// M0 and M1 and three slaves (S0, S1, default slave SD).
//
// - Decodes araddr[ADDR_BITS-1:16]: 0x0000 -> S0, 0x0001 -> S1, else SD.
// - Prepends the master index to the ID: arids_s_o = {index, id}.
// - Keeps each slave locked (busy) from capture until its rdone_i pulse, so
//   at most one read is outstanding per slave and R data never interleaves.
// - Two-state FSM: IDLE captures a winner (arready pulses in that cycle),
//   ADDR presents the registered request until the target slave accepts it.
//
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-low reset
//   bus - ar_arbiter_if.master, all AR/rdone signals
//
// Build option: define AR_RR_EN for round-robin arbitration between M0 and
// M1; without it M0 has fixed priority over M1.
module ar_arbiter #(
    parameter int unsigned ID_BITS   = 4,
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned LEN_BITS  = 4
) (
    input logic            clk,
    input logic            rst,
    ar_arbiter_if.master   bus
);

    localparam int unsigned HI_BITS = ADDR_BITS - 16;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StAddr = 1'b1;

    // One-hot slave select: bit0 = S0, bit1 = S1, bit2 = SD.
    function automatic logic [2:0] decode(input logic [ADDR_BITS-1:0] addr);
        logic [HI_BITS-1:0] hi;
        hi = addr[ADDR_BITS-1:16];
        if (hi == '0) begin
            return 3'b001;
        end else if (hi == HI_BITS'(1)) begin
            return 3'b010;
        end else begin
            return 3'b100;
        end
    endfunction

    logic [0:0]           state_q, state_d;
    logic [2:0]           busy_q, busy_d;
    logic [2:0]           tgt_q, tgt_d;
    logic [ID_BITS:0]     ids_q, ids_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [LEN_BITS-1:0]  len_q, len_d;

    logic [2:0] tgt_m0, tgt_m1;
    logic       elig_m0, elig_m1;
    logic       idle;
    logic       gnt_m0, gnt_m1;

    assign tgt_m0  = decode(bus.araddr_m0_i);
    assign tgt_m1  = decode(bus.araddr_m1_i);
    assign elig_m0 = bus.arvalid_m0_i & ~|(tgt_m0 & busy_q);
    assign elig_m1 = bus.arvalid_m1_i & ~|(tgt_m1 & busy_q);
    assign idle    = (state_q == StIdle);

`ifdef AR_RR_EN
    // prio_q names the favoured master (0 = M0); it flips to the loser after
    // every grant, including uncontested ones.
    logic prio_q, prio_d;

    assign gnt_m0 = idle & elig_m0 & (~elig_m1 | ~prio_q);
    assign gnt_m1 = idle & elig_m1 & (~elig_m0 |  prio_q);

    always_comb begin
        prio_d = prio_q;
        if (gnt_m0) begin
            prio_d = 1'b1;
        end else if (gnt_m1) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    assign gnt_m0 = idle & elig_m0;
    assign gnt_m1 = idle & elig_m1 & ~elig_m0;
`endif

    // Gated with rst so no handshake is signalled while the capture is
    // being suppressed by reset.
    assign bus.arready_m0_o = gnt_m0 & rst;
    assign bus.arready_m1_o = gnt_m1 & rst;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        ids_d   = ids_q;
        addr_d  = addr_q;
        len_d   = len_q;
        // rdone only clears a set bit; capture targets a non-busy slave, so
        // the two never collide on the same bit.
        busy_d  = busy_q & ~bus.rdone_i;

        unique case (state_q)
            StIdle: begin
                if (gnt_m0) begin
                    state_d = StAddr;
                    tgt_d   = tgt_m0;
                    ids_d   = {1'b0, bus.arid_m0_i};
                    addr_d  = bus.araddr_m0_i;
                    len_d   = bus.arlen_m0_i;
                    busy_d  = busy_d | tgt_m0;
                end else if (gnt_m1) begin
                    state_d = StAddr;
                    tgt_d   = tgt_m1;
                    ids_d   = {1'b1, bus.arid_m1_i};
                    addr_d  = bus.araddr_m1_i;
                    len_d   = bus.arlen_m1_i;
                    busy_d  = busy_d | tgt_m1;
                end
            end
            StAddr: begin
                // Only the target slave's ready matters.
                if (|(bus.arready_s_i & tgt_q)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            busy_q  <= '0;
            tgt_q   <= '0;
            ids_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            tgt_q   <= tgt_d;
            ids_q   <= ids_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    assign bus.arvalid_s_o = (state_q == StAddr) ? tgt_q : 3'b000;
    assign bus.arids_s_o   = ids_q;
    assign bus.araddr_s_o  = addr_q;
    assign bus.arlen_s_o   = len_q;

endmodule

// File: tb/tb_ar_arbiter.sv
// tb_ar_arbiter: self-checking bench for ar_arbiter.
// Decode table, hand-written corner sequences, then randomized traffic
// compared against a queue-based reference model.
module tb_ar_arbiter;

    localparam int unsigned IDB = 4;
    localparam int unsigned AB  = 32;
    localparam int unsigned LB  = 4;
`ifdef AR_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ar_arbiter_if #(.ID_BITS(IDB), .ADDR_BITS(AB), .LEN_BITS(LB)) bus ();

    ar_arbiter #(.ID_BITS(IDB), .ADDR_BITS(AB), .LEN_BITS(LB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [3:0]  id;
        logic [3:0]  len;
        logic [2:0]  exp_valid;
        logic [4:0]  exp_ids;
    } vec_t;

    typedef struct {
        int          slv;
        logic [4:0]  ids;
        logic [31:0] addr;
        logic [3:0]  len;
    } ar_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rdy(input int m);
        return (m == 1) ? bus.arready_m1_o : bus.arready_m0_o;
    endfunction

    function automatic int slave_of(input logic [31:0] a);
        int hi;
        hi = int'(a >> 16);
        if (hi == 0) return 0;
        if (hi == 1) return 1;
        return 2;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int m, input logic v, input logic [31:0] a,
                           input logic [3:0] id, input logic [3:0] len);
        if (m == 0) begin
            bus.arvalid_m0_i = v; bus.araddr_m0_i = a; bus.arid_m0_i = id; bus.arlen_m0_i = len;
        end else begin
            bus.arvalid_m1_i = v; bus.araddr_m1_i = a; bus.arid_m1_i = id; bus.arlen_m1_i = len;
        end
    endtask

    task automatic idle_inputs();
        drive_m(0, 1'b0, 32'h0, 4'h0, 4'h0);
        drive_m(1, 1'b0, 32'h0, 4'h0, 4'h0);
        bus.arready_s_i = 3'b000;
        bus.rdone_i     = 3'b000;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        step();
        rst = 1'b1;
    endtask

    vec_t vecs[7];

    // Reference model state
    bit   m_busy[3];
    ar_t  m_pend[$];
    int   m_prio;

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic        v[2];
        logic [31:0] a[2];
        logic [3:0]  id[2];
        logic [3:0]  ln[2];
        bit          acc[2];
        bit          el[2];
        int          w;
        int          win;
        logic [2:0]  rd;
        logic [2:0]  ev;
        logic [31:0] r32;

        vecs[0] = '{0, 32'h0000_0040, 4'h3, 4'h3, 3'b001, 5'b0_0011};
        vecs[1] = '{1, 32'h0001_2000, 4'hA, 4'h1, 3'b010, 5'b1_1010};
        vecs[2] = '{0, 32'h8000_0000, 4'h5, 4'hF, 3'b100, 5'b0_0101};
        vecs[3] = '{1, 32'h0002_0000, 4'h0, 4'h2, 3'b100, 5'b1_0000};
        vecs[4] = '{0, 32'h0000_FFFF, 4'hF, 4'h0, 3'b001, 5'b0_1111};
        vecs[5] = '{1, 32'h0001_FFFF, 4'h7, 4'h7, 3'b010, 5'b1_0111};
        vecs[6] = '{0, 32'hFFFF_0000, 4'h9, 4'h4, 3'b100, 5'b0_1001};

        // Reset values, with a request pending to prove arready stays low.
        rst = 1'b0;
        idle_inputs();
        drive_m(0, 1'b1, 32'h0000_0040, 4'h3, 4'h3);
        step();
        @(negedge clk);
        chk("rst_arready_m0", bus.arready_m0_o, 1'b0);
        chk("rst_arready_m1", bus.arready_m1_o, 1'b0);
        chk("rst_arvalid_s", bus.arvalid_s_o, 3'b000);
        chk("rst_arids", bus.arids_s_o, 5'h0);
        chk("rst_araddr", bus.araddr_s_o, 32'h0);
        chk("rst_arlen", bus.arlen_s_o, 4'h0);

        // Decode table
        for (int i = 0; i < 7; i++) begin
            do_reset();
            drive_m(vecs[i].m, 1'b1, vecs[i].addr, vecs[i].id, vecs[i].len);
            @(negedge clk);
            chk("dec_rdy", rdy(vecs[i].m), 1'b1);
            chk("dec_other_rdy", rdy(1 - vecs[i].m), 1'b0);
            chk("dec_no_valid_yet", bus.arvalid_s_o, 3'b000);
            step();
            drive_m(vecs[i].m, 1'b0, 32'h0, 4'h0, 4'h0);
            bus.arready_s_i = 3'b111;
            @(negedge clk);
            chk("dec_valid", bus.arvalid_s_o, vecs[i].exp_valid);
            chk("dec_ids", bus.arids_s_o, vecs[i].exp_ids);
            chk("dec_addr", bus.araddr_s_o, vecs[i].addr);
            chk("dec_len", bus.arlen_s_o, vecs[i].len);
            step();
            bus.arready_s_i = 3'b000;
            @(negedge clk);
            chk("dec_drop", bus.arvalid_s_o, 3'b000);
        end

        // Busy lock on S0
        do_reset();
        drive_m(0, 1'b1, 32'h0000_0040, 4'h3, 4'h3);
        @(negedge clk);
        chk("lock_first_rdy", bus.arready_m0_o, 1'b1);
        step();
        drive_m(0, 1'b0, 32'h0, 4'h0, 4'h0);
        bus.arready_s_i = 3'b001;
        @(negedge clk);
        chk("lock_first_valid", bus.arvalid_s_o, 3'b001);
        step();
        bus.arready_s_i = 3'b000;
        drive_m(1, 1'b1, 32'h0000_1000, 4'h6, 4'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lock_wait", bus.arready_m1_o, 1'b0);
            step();
        end
        bus.rdone_i = 3'b001;
        @(negedge clk);
        chk("lock_rdone_cycle", bus.arready_m1_o, 1'b0);
        step();
        bus.rdone_i = 3'b000;
        @(negedge clk);
        chk("lock_release", bus.arready_m1_o, 1'b1);
        step();
        drive_m(1, 1'b0, 32'h0, 4'h0, 4'h0);
        @(negedge clk);
        chk("lock_valid", bus.arvalid_s_o, 3'b001);
        chk("lock_ids", bus.arids_s_o, 5'h16);

        // Contention on S1
        do_reset();
        drive_m(0, 1'b1, 32'h0001_0000, 4'h1, 4'h0);
        drive_m(1, 1'b1, 32'h0001_0004, 4'h2, 4'h0);
        for (int g = 0; g < 3; g++) begin
            w = RR ? (g % 2) : 0;
            @(negedge clk);
            chk("cont_winner_rdy", rdy(w), 1'b1);
            chk("cont_loser_rdy", rdy(1 - w), 1'b0);
            step();
            bus.arready_s_i = 3'b010;
            @(negedge clk);
            chk("cont_valid", bus.arvalid_s_o, 3'b010);
            chk("cont_index", bus.arids_s_o[4], w[0]);
            step();
            bus.arready_s_i = 3'b000;
            bus.rdone_i = 3'b010;
            @(negedge clk);
            chk("cont_busy_rdy", bus.arready_m0_o | bus.arready_m1_o, 1'b0);
            step();
            bus.rdone_i = 3'b000;
        end

        // Bypass: M0 blocked on S0, M1 goes to SD
        do_reset();
        drive_m(0, 1'b1, 32'h0000_0040, 4'h3, 4'h3);
        step();
        drive_m(0, 1'b0, 32'h0, 4'h0, 4'h0);
        bus.arready_s_i = 3'b001;
        step();
        bus.arready_s_i = 3'b000;
        drive_m(0, 1'b1, 32'h0000_0100, 4'h4, 4'h0);
        drive_m(1, 1'b1, 32'h8000_0000, 4'h9, 4'h1);
        @(negedge clk);
        chk("bypass_m1_rdy", bus.arready_m1_o, 1'b1);
        chk("bypass_m0_rdy", bus.arready_m0_o, 1'b0);
        step();
        drive_m(1, 1'b0, 32'h0, 4'h0, 4'h0);
        bus.arready_s_i = 3'b100;
        @(negedge clk);
        chk("bypass_valid", bus.arvalid_s_o, 3'b100);
        chk("bypass_ids", bus.arids_s_o, 5'h19);
        step();
        bus.arready_s_i = 3'b000;
        @(negedge clk);
        chk("bypass_m0_wait", bus.arready_m0_o, 1'b0);
        chk("bypass_drop", bus.arvalid_s_o, 3'b000);

        // Slave stall on S1, other readies toggled and ignored
        do_reset();
        drive_m(1, 1'b1, 32'h0001_0040, 4'h5, 4'h7);
        step();
        drive_m(1, 1'b0, 32'h0, 4'h0, 4'h0);
        drive_m(0, 1'b1, 32'h9000_0000, 4'hC, 4'h2);
        bus.arready_s_i = 3'b101;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", bus.arvalid_s_o, 3'b010);
            chk("stall_ids", bus.arids_s_o, 5'h15);
            chk("stall_addr", bus.araddr_s_o, 32'h0001_0040);
            chk("stall_len", bus.arlen_s_o, 4'h7);
            chk("stall_no_capture", bus.arready_m0_o, 1'b0);
            step();
        end
        bus.arready_s_i = 3'b010;
        @(negedge clk);
        chk("stall_hs_valid", bus.arvalid_s_o, 3'b010);
        chk("stall_hs_no_capture", bus.arready_m0_o, 1'b0);
        step();
        bus.arready_s_i = 3'b000;
        @(negedge clk);
        chk("stall_after_valid", bus.arvalid_s_o, 3'b000);
        chk("stall_next_capture", bus.arready_m0_o, 1'b1);

        // Reset while in ADDR
        do_reset();
        drive_m(0, 1'b1, 32'h0000_0040, 4'h3, 4'h3);
        step();
        drive_m(0, 1'b0, 32'h0, 4'h0, 4'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_before", bus.arvalid_s_o, 3'b001);
        step();
        rst = 1'b1;
        drive_m(1, 1'b1, 32'h0000_0200, 4'h1, 4'h0);
        @(negedge clk);
        chk("midrst_valid", bus.arvalid_s_o, 3'b000);
        chk("midrst_ids", bus.arids_s_o, 5'h0);
        chk("midrst_addr", bus.araddr_s_o, 32'h0);
        chk("midrst_len", bus.arlen_s_o, 4'h0);
        chk("midrst_busy_cleared", bus.arready_m1_o, 1'b1);

        // Randomized traffic against the reference model
        do_reset();
        for (int s = 0; s < 3; s++) m_busy[s] = 1'b0;
        m_pend.delete();
        m_prio = 0;
        for (int m = 0; m < 2; m++) begin
            v[m] = 1'b0; a[m] = '0; id[m] = '0; ln[m] = '0; acc[m] = 1'b0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                // A master keeps its request until it is accepted.
                if (!(v[m] && !acc[m])) begin
                    v[m] = 1'($urandom % 2);
                    r32 = $urandom;
                    case ($urandom % 3)
                        0: a[m] = {16'h0000, r32[15:0]};
                        1: a[m] = {16'h0001, r32[15:0]};
                        default: a[m] = r32;
                    endcase
                    id[m] = 4'($urandom);
                    ln[m] = 4'($urandom);
                end
                drive_m(m, v[m], a[m], id[m], ln[m]);
            end
            bus.arready_s_i = 3'($urandom);
            rd = 3'b000;
            for (int s = 0; s < 3; s++) begin
                if (m_busy[s] && !(m_pend.size() > 0 && m_pend[0].slv == s)
                    && ($urandom % 4 == 0)) begin
                    rd[s] = 1'b1;
                end
            end
            bus.rdone_i = rd;
            rst = ($urandom % 300) != 0;

            @(negedge clk);
            for (int m = 0; m < 2; m++) el[m] = v[m] && !m_busy[slave_of(a[m])];
            win = -1;
            if (m_pend.size() == 0 && rst) begin
                if (el[0] && el[1]) win = RR ? m_prio : 0;
                else if (el[0]) win = 0;
                else if (el[1]) win = 1;
            end
            chk("rnd_arready_m0", bus.arready_m0_o, win == 0);
            chk("rnd_arready_m1", bus.arready_m1_o, win == 1);
            ev = (m_pend.size() > 0) ? 3'(1 << m_pend[0].slv) : 3'b000;
            chk("rnd_arvalid_s", bus.arvalid_s_o, ev);
            if (m_pend.size() > 0) begin
                chk("rnd_arids", bus.arids_s_o, m_pend[0].ids);
                chk("rnd_araddr", bus.araddr_s_o, m_pend[0].addr);
                chk("rnd_arlen", bus.arlen_s_o, m_pend[0].len);
            end
            for (int m = 0; m < 2; m++) acc[m] = (win == m);

            if (!rst) begin
                for (int s = 0; s < 3; s++) m_busy[s] = 1'b0;
                m_pend.delete();
                m_prio = 0;
            end else begin
                if (m_pend.size() > 0 && bus.arready_s_i[m_pend[0].slv]) void'(m_pend.pop_front());
                for (int s = 0; s < 3; s++) if (rd[s]) m_busy[s] = 1'b0;
                if (win >= 0) begin
                    m_pend.push_back('{slave_of(a[win]), {win[0], id[win]}, a[win], ln[win]});
                    m_busy[slave_of(a[win])] = 1'b1;
                    m_prio = 1 - win;
                end
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
